// File: rtl/spi_rx.sv
// SPI mode-0 receiver: oversamples scl/sda/cs on clk, assembles MSB-first bytes
// and queues them in a first-word-fall-through FIFO for the local controller.
module spi_rx #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda,
    input  logic       cs,
    input  logic       rd_en,
    input  logic       clr_ovf,
    output logic [7:0] data_out,
    output logic       empty,
    output logic       full,
    output logic       valid,
    output logic       overflow,
    output logic       frame_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned SW = $clog2(SYNC_STAGES + 2);
    localparam logic [SW-1:0] SETTLE = SW'(SYNC_STAGES + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync, cs_sync;
    logic                   scl_prev, cs_prev;
    logic                   scl_s, sda_s, cs_s;
    logic                   scl_rise, cs_fall, cs_rise;
    logic [SW-1:0]          settle_cnt;
    logic                   settled;

    logic [2:0] bit_cnt, cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic       byte_done, ferr_next;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        push, pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '0;
            sda_sync <= '0;
            cs_sync  <= '1;
            scl_prev <= 1'b0;
            cs_prev  <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            cs_prev  <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];
    assign cs_s  = cs_sync[SYNC_STAGES-1];

    // The cs path resets to 1, so a cs held low through reset would look like a
    // falling edge once the chain fills; cs edges are ignored until it has.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            settle_cnt <= '0;
        else if (settle_cnt != SETTLE)
            settle_cnt <= settle_cnt + 1'b1;
    end

    assign settled  = (settle_cnt == SETTLE);
    assign scl_rise = scl_s & ~scl_prev;
    assign cs_fall  = settled & ~cs_s & cs_prev;
    assign cs_rise  = settled & cs_s & ~cs_prev;

    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        shift_next = shift_reg;
        byte_done  = 1'b0;
        ferr_next  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (cs_fall)
                    state_next = SHIFT;
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    ferr_next  = (bit_cnt != 3'd0);
                    cnt_next   = '0;
                end else if (scl_rise) begin
                    shift_next = {shift_reg[6:0], sda_s};
                    if (bit_cnt == 3'd7) begin
                        byte_done = 1'b1;
                        cnt_next  = '0;
                    end else begin
                        cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop   = rd_en & ~empty;
    assign push  = byte_done & (~full | pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= cnt_next;
            shift_reg <= shift_next;
            valid     <= byte_done;
            frame_err <= ferr_next;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (byte_done && !push)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= shift_next;
    end

    assign data_out = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_spi_rx.sv
// Scoreboard bench for spi_rx: bytes sent are queued as expected FIFO contents
// and checked on readout, alongside valid/frame_err/overflow behaviour.
module tb_spi_rx;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYNC  = 2;

    logic       clk = 1'b0;
    logic       reset, scl, sda, cs, rd_en, clr_ovf;
    logic [7:0] data_out;
    logic       empty, full, valid, overflow, frame_err;

    int n_checks = 0;
    int n_pass   = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;

    spi_rx #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda), .cs(cs),
        .rd_en(rd_en), .clr_ovf(clr_ovf), .data_out(data_out), .empty(empty),
        .full(full), .valid(valid), .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid)     valid_cnt++;
        if (frame_err) ferr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // scl high/low for 4 clk each; optional rd_en lands on the edge where this
    // bit's rising scl completes a byte
    task automatic send_bit(input logic b, input bit pop_last);
        sda = b;
        wait_clk(4);
        scl = 1'b1;
        if (pop_last) begin
            wait_clk(SYNC);
            check("pop_head", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
            rd_en = 1'b1;
            wait_clk(1);
            rd_en = 1'b0;
            wait_clk(4 - (SYNC + 1));
        end else begin
            wait_clk(4);
        end
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit pop_last);
        for (int i = 7; i >= 0; i--)
            send_bit(b[i], pop_last && (i == 0));
        wait_clk(4);
        if (exp_q.size() < DEPTH)
            exp_q.push_back(b);
        else
            exp_ovf = 1'b1;
    endtask

    task automatic read_byte(input string tag);
        check(tag, {24'h0, data_out}, {24'h0, exp_q.pop_front()});
        rd_en = 1'b1;
        wait_clk(1);
        rd_en = 1'b0;
    endtask

    task automatic frame_start();
        cs = 1'b0;
        wait_clk(6);
    endtask

    task automatic frame_end();
        cs = 1'b1;
        wait_clk(6);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0;
        reset = 1'b1; scl = 1'b0; sda = 1'b0; cs = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0;
        wait_clk(3);
        check("rst_data", {24'h0, data_out}, 32'h0);
        check("rst_empty", {31'h0, empty}, 32'h1);
        check("rst_full", {31'h0, full}, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);
        reset = 1'b0;
        wait_clk(6);

        // single byte
        v0 = valid_cnt; f0 = ferr_cnt;
        frame_start();
        send_byte(8'hA5, 1'b0);
        frame_end();
        check("t1_valid", valid_cnt - v0, 1);
        check("t1_ferr", ferr_cnt - f0, 0);
        check("t1_empty", {31'h0, empty}, 32'h0);
        read_byte("t1_data");
        check("t1_empty_after", {31'h0, empty}, 32'h1);
        check("t1_data_after", {24'h0, data_out}, 32'h0);

        // overflow
        v0 = valid_cnt;
        frame_start();
        for (int i = 1; i <= 4; i++)
            send_byte(8'(i), 1'b0);
        check("t2_full", {31'h0, full}, 32'h1);
        check("t2_ovf_pre", {31'h0, overflow}, {31'h0, exp_ovf});
        send_byte(8'h05, 1'b0);
        frame_end();
        check("t2_valid", valid_cnt - v0, 5);
        check("t2_ovf", {31'h0, overflow}, {31'h0, exp_ovf});
        for (int i = 0; i < 4; i++)
            read_byte("t2_data");
        check("t2_empty", {31'h0, empty}, 32'h1);
        clr_ovf = 1'b1;
        wait_clk(1);
        clr_ovf = 1'b0;
        exp_ovf = 1'b0;
        check("t2_clr", {31'h0, overflow}, 32'h0);

        // push and pop in the same cycle while full
        frame_start();
        for (int i = 1; i <= 4; i++)
            send_byte(8'(i), 1'b0);
        send_byte(8'h55, 1'b1);
        frame_end();
        check("t3_full", {31'h0, full}, 32'h1);
        check("t3_ovf", {31'h0, overflow}, {31'h0, exp_ovf});
        for (int i = 0; i < 4; i++)
            read_byte("t3_data");
        check("t3_empty", {31'h0, empty}, 32'h1);

        // partial frame
        v0 = valid_cnt; f0 = ferr_cnt;
        frame_start();
        for (int i = 0; i < 3; i++)
            send_bit(1'b1, 1'b0);
        wait_clk(4);
        frame_end();
        check("t4_ferr", ferr_cnt - f0, 1);
        check("t4_valid", valid_cnt - v0, 0);
        check("t4_empty", {31'h0, empty}, 32'h1);
        frame_start();
        send_byte(8'h3C, 1'b0);
        frame_end();
        read_byte("t4_data");

        // scl activity with cs high
        v0 = valid_cnt; f0 = ferr_cnt;
        for (int i = 0; i < 8; i++)
            send_bit(i[0], 1'b0);
        wait_clk(6);
        check("t5_valid", valid_cnt - v0, 0);
        check("t5_empty", {31'h0, empty}, 32'h1);
        frame_start();
        send_byte(8'h96, 1'b0);
        frame_end();
        check("t5_ferr", ferr_cnt - f0, 0);
        read_byte("t5_data");

        // reset mid-frame with cs held low
        v0 = valid_cnt; f0 = ferr_cnt;
        frame_start();
        for (int i = 0; i < 5; i++)
            send_bit(1'b1, 1'b0);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        for (int i = 0; i < 8; i++)
            send_bit(1'b1, 1'b0);
        wait_clk(6);
        check("t6_valid", valid_cnt - v0, 0);
        check("t6_empty", {31'h0, empty}, 32'h1);
        check("t6_full", {31'h0, full}, 32'h0);
        check("t6_data", {24'h0, data_out}, 32'h0);
        check("t6_ovf", {31'h0, overflow}, 32'h0);
        frame_end();
        check("t6_ferr", ferr_cnt - f0, 0);
        frame_start();
        send_byte(8'h5A, 1'b0);
        frame_end();
        read_byte("t6_data_after");
        check("t6_empty_after", {31'h0, empty}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_rx.md
# spi_rx

SPI receiver for the SPI link: mode 0 (CPOL=0, CPHA=0), MSB-first, 8-bit frames. It oversamples the incoming SCL/SDA/CS lines on the system clock and assembles bytes. Completed bytes go into a small first-word-fall-through FIFO that the local controller drains. It sits at the far end of the link from the SPI transmitter and turns the serial stream back into bytes for the elevator control logic.

## Interface
- FIFO_DEPTH, 4, byte FIFO entries; power of two, ≥2
- SYNC_STAGES, 2, flip-flop stages on scl/sda/cs before edge detection; ≥2
- clk  input  1  system clock; frequency ≥ 4× SCL frequency
- reset  input  1  reset, asynchronous, active-high
- scl  input  1  serial clock, idles low, asynchronous to clk
- sda  input  1  serial data, stable around SCL rising edge
- cs  input  1  chip select, active low, asynchronous to clk
- rd_en  input  1  pop head byte at clock edge; ignored when empty
- clr_ovf  input  1  clears overflow
- data_out  output  8  FIFO head byte; 8'h00 whenever empty=1
- empty  output  1  FIFO holds no bytes
- full  output  1  FIFO holds FIFO_DEPTH bytes
- valid  output  1  one-cycle pulse when a byte completes (including a dropped byte)
- overflow  output  1  sticky: a completed byte was dropped because the FIFO was full
- frame_err  output  1  one-cycle pulse: cs deasserted mid-byte

## Operation
- scl, sda and cs each pass through a SYNC_STAGES synchronizer. One more register holds the previous synchronized scl and cs for edge detection. sda is taken from the same synchronizer depth as scl, so the two stay aligned.
- FSM states:
  - IDLE: synchronized cs=1. Bit counter held at 0. scl edges ignored.
  - SHIFT: entered on a synchronized cs falling edge. Bit counter cleared to 0.
- On each synchronized scl rising edge in SHIFT:
  - shift_reg <= {shift_reg[6:0], sda_sync}
  - bit counter increments
- When the bit counter reaches 8:
  - The byte completes and the counter wraps to 0. The FSM stays in SHIFT, so back-to-back bytes need no cs toggle.
  - If the FIFO is not full, or a pop happens in the same cycle, the byte is pushed.
  - Otherwise the byte is dropped and overflow is set.
  - valid pulses in both cases.
- Synchronized cs rising edge in SHIFT:
  - The FSM returns to IDLE.
  - If the bit counter is nonzero (1..7), frame_err pulses for one cycle and the partial byte is discarded.
  - Counter 0 (clean byte boundary) ends the frame with no error.
- FIFO:
  - Circular buffer with rd/wr pointers of log2(FIFO_DEPTH) bits plus one wrap bit.
  - full when the pointers are equal and the wrap bits differ; empty when the pointers and wrap bits are equal.
  - Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop:
  - When full: both happen, full stays 1, no overflow.
  - When empty: the pop is ignored and the push happens.
- overflow: set by a dropped byte, cleared by clr_ovf. If set and clear happen in the same cycle, set wins.
- Reset mid-frame:
  - All state is cleared and the partial byte is lost.
  - After reset release the FSM stays in IDLE until a fresh cs falling edge is seen.
  - A cs held low through reset is not treated as a frame start.

## Timing
- Reset values:
  - data_out=8'h00, empty=1, full=0, valid=0, overflow=0, frame_err=0
  - FSM in IDLE, bit counter 0, shift_reg 0, pointers 0
  - synchronizers and edge registers 0 except the cs path, which resets to 1
- Edge detect latency: an input transition is seen as an edge SYNC_STAGES+1 clk cycles after the first sampling clk edge.
- Push latency:
  - The 8th scl edge is detected in cycle N.
  - In cycle N+1: FIFO written, valid=1, empty falls, data_out shows the byte.
- Pop:
  - Cycle in which rd_en=1 with empty=0: the head is consumed at that clock edge.
  - The next head (or 8'h00 with empty=1) appears the following cycle.
- frame_err asserts the cycle after the cs rising edge is detected and lasts one cycle.
- Minimum SCL high and low times are each ≥ 2 clk periods. Faster SCL is outside spec.

## Test plan
- cs low, shift 8'hA5 MSB-first at clk/8 SCL, cs high → valid pulses once, empty=0, data_out=8'hA5, frame_err=0. rd_en for one cycle → empty=1, data_out=8'h00.
- One cs-low frame carrying 8'h01,8'h02,8'h03,8'h04,8'h05 with no reads → full=1 after the 4th byte. The 5th byte raises valid and overflow. Reads return 01,02,03,04. clr_ovf → overflow=0.
- FIFO full and a byte completing in the same cycle as rd_en=1 → no overflow, full stays 1, later reads return 02,03,04,new byte.
- cs low, 3 scl pulses, cs high → frame_err pulses once, no valid, empty stays 1. The next full frame with 8'h3C → data_out=8'h3C.
- scl toggled 8 times with cs high → no valid, empty=1, bit counter unchanged.
- reset asserted after 5 bits of 8'hFF, released with cs still low, then 8 more scl pulses → no valid, all outputs at reset values.
